// File: rtl/clock_set_sequencer.sv
// Front-panel time-setting sequencer for clock_control: mode stepping, press/auto-repeat strobes,
// inactivity timeout and blink flag. Auto-repeat is built only when SET_AUTO_REPEAT_EN is defined.
module clock_set_sequencer #(
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned TIMEOUT      = 10000,
  parameter int unsigned BLINK_HALF   = 250
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_wr,
  output logic [1:0] o_sel,
  output logic       o_inc_pulse,
  output logic       o_dec_pulse,
  output logic       o_blink
);

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] ST_RUN  = 3'd0;
  localparam logic [2:0] ST_SET0 = 3'd1;
  localparam logic [2:0] ST_SET1 = 3'd2;
  localparam logic [2:0] ST_SET2 = 3'd3;
  localparam logic [2:0] ST_SET3 = 3'd4;

  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

  logic [2:0]       state_q, state_d;
  logic             up_q, dn_q;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_d, inc_d, dec_d, wr_d;
  logic [1:0]       sel_d;

  logic in_set, any_btn, both_btn, press_up, press_dn, tmo_hit, state_chg;

  assign in_set    = (state_q != ST_RUN);
  assign any_btn   = i_btn_up | i_btn_down;
  assign both_btn  = i_btn_up & i_btn_down;
  assign press_up  = i_btn_up & ~up_q;
  assign press_dn  = i_btn_down & ~dn_q;
  assign tmo_hit   = in_set & i_tick & ~any_btn & (tmo_cnt_q == TMO_LAST);
  assign state_chg = i_btn_mode | tmo_hit;

`ifdef SET_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  // The act flags mark the single button whose press is still being honoured for repeat.
  logic             up_act_q, up_act_d, dn_act_q, dn_act_d;
  logic             rep_fast_q, rep_fast_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] rep_last;

  assign rep_last = rep_fast_q ? RATE_LAST : DELAY_LAST;
`endif

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = o_blink;
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    wr_d        = 1'b0;
    sel_d       = 2'd0;
`ifdef SET_AUTO_REPEAT_EN
    up_act_d    = up_act_q;
    dn_act_d    = dn_act_q;
    rep_fast_d  = rep_fast_q;
    rep_cnt_d   = rep_cnt_q;
`endif

    case (state_q)
      ST_RUN:  if (i_btn_mode) state_d = ST_SET0;
      ST_SET0: if (i_btn_mode) state_d = ST_SET1; else if (tmo_hit) state_d = ST_RUN;
      ST_SET1: if (i_btn_mode) state_d = ST_SET2; else if (tmo_hit) state_d = ST_RUN;
      ST_SET2: if (i_btn_mode) state_d = ST_SET3; else if (tmo_hit) state_d = ST_RUN;
      ST_SET3: if (state_chg) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    // Any state change (or sitting in RUN) discards presses and restarts every count.
    if (!in_set || state_chg) begin
      tmo_cnt_d   = '0;
      blink_cnt_d = '0;
      blink_d     = 1'b0;
`ifdef SET_AUTO_REPEAT_EN
      up_act_d    = 1'b0;
      dn_act_d    = 1'b0;
      rep_fast_d  = 1'b0;
      rep_cnt_d   = '0;
`endif
    end else begin
      if (i_tick) tmo_cnt_d = any_btn ? '0 : tmo_cnt_q + CNT_W'(1);

      if (any_btn) begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
      end else if (i_tick) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_d     = ~o_blink;
        end else begin
          blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end
      end

      inc_d = press_up & ~i_btn_down;
      dec_d = press_dn & ~i_btn_up;

`ifdef SET_AUTO_REPEAT_EN
      if (both_btn) begin
        up_act_d   = 1'b0;
        dn_act_d   = 1'b0;
        rep_fast_d = 1'b0;
        rep_cnt_d  = '0;
      end else if (inc_d | dec_d) begin
        up_act_d   = inc_d;
        dn_act_d   = dec_d;
        rep_fast_d = 1'b0;
        rep_cnt_d  = '0;
      end else if ((up_act_q & i_btn_up) | (dn_act_q & i_btn_down)) begin
        if (i_tick) begin
          if (rep_cnt_q == rep_last) begin
            rep_cnt_d  = '0;
            rep_fast_d = 1'b1;
            inc_d      = up_act_q;
            dec_d      = dn_act_q;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
          end
        end
      end else begin
        up_act_d   = 1'b0;
        dn_act_d   = 1'b0;
        rep_fast_d = 1'b0;
        rep_cnt_d  = '0;
      end
`else
      if (both_btn) begin
        inc_d = 1'b0;
        dec_d = 1'b0;
      end
`endif
    end

    case (state_d)
      ST_SET0: begin wr_d = 1'b1; sel_d = 2'd0; end
      ST_SET1: begin wr_d = 1'b1; sel_d = 2'd1; end
      ST_SET2: begin wr_d = 1'b1; sel_d = 2'd2; end
      ST_SET3: begin wr_d = 1'b1; sel_d = 2'd3; end
      default: begin wr_d = 1'b0; sel_d = 2'd0; end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      tmo_cnt_q   <= '0;
      blink_cnt_q <= '0;
      o_wr        <= 1'b0;
      o_sel       <= 2'd0;
      o_inc_pulse <= 1'b0;
      o_dec_pulse <= 1'b0;
      o_blink     <= 1'b0;
`ifdef SET_AUTO_REPEAT_EN
      up_act_q    <= 1'b0;
      dn_act_q    <= 1'b0;
      rep_fast_q  <= 1'b0;
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      up_q        <= i_btn_up;
      dn_q        <= i_btn_down;
      tmo_cnt_q   <= tmo_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      o_wr        <= wr_d;
      o_sel       <= sel_d;
      o_inc_pulse <= inc_d;
      o_dec_pulse <= dec_d;
      o_blink     <= blink_d;
`ifdef SET_AUTO_REPEAT_EN
      up_act_q    <= up_act_d;
      dn_act_q    <= dn_act_d;
      rep_fast_q  <= rep_fast_d;
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

endmodule
